alu_sequencer: RTL and testbench

Upstream command stage for the 8-bit ALU. It buffers operation requests in a small FIFO and drives the ALU operand and control inputs (x, y, s, L, En) for a programmable number of cycles. It then captures the ALU result f and cout and presents them downstream on a valid/ready handshake. It serialises ALU use, so adder, shift, counter and logic operations can be queued back-to-back.

---
 rtl/alu_sequencer.sv | 179 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Command sequencer in front of the 8-bit ALU. It queues requests, drives the ALU
// for a per-command number of cycles, then holds the captured result on a valid/ready port.
module alu_sequencer #(
    parameter int DEPTH = 4,
    parameter int CW    = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [7:0]                 cmd_x,
    input  logic [7:0]                 cmd_y,
    input  logic                       cmd_l,
    input  logic                       cmd_en,
    input  logic [CW-1:0]              cmd_cyc,
    output logic [7:0]                 alu_x,
    output logic [7:0]                 alu_y,
    output logic [1:0]                 alu_s,
    output logic                       alu_l,
    output logic                       alu_en,
    input  logic [7:0]                 alu_f,
    input  logic                       alu_cout,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [7:0]                 res_data,
    output logic                       res_cout,
    output logic [1:0]                 res_op,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int EW = 20 + CW;

    typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, RESP = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [EW-1:0]   mem_q [DEPTH];
    logic [EW-1:0]   mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            full, empty, push, pop;
    logic [EW-1:0]   rd_entry;

    logic [1:0]      op_q, op_d;
    logic [7:0]      x_q, x_d, y_q, y_d;
    logic            l_q, l_d, en_q, en_d;
    logic [CW-1:0]   cyc_q, cyc_d, cnt_q, cnt_d;

    logic            res_valid_q, res_valid_d;
    logic [7:0]      res_data_q, res_data_d;
    logic            res_cout_q, res_cout_d;
    logic [1:0]      res_op_q, res_op_d;

    // No bypass: a full FIFO refuses pushes even when it is being popped.
    assign full     = (level_q == LW'(DEPTH));
    assign empty    = (level_q == '0);
    assign push     = cmd_valid && !full;
    assign pop      = (state_q == IDLE) && !empty;
    assign rd_entry = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = {cmd_op, cmd_x, cmd_y, cmd_l, cmd_en, cmd_cyc};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      level_d = level_q + LW'(1);
        else if (!push && pop) level_d = level_q - LW'(1);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty) state_d = DRIVE;
            DRIVE:   if (cnt_q == '0) state_d = RESP;
            RESP:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        {op_d, x_d, y_d, l_d, en_d, cyc_d} = {op_q, x_q, y_q, l_q, en_q, cyc_q};
        cnt_d       = cnt_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_cout_d  = res_cout_q;
        res_op_d    = res_op_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    {op_d, x_d, y_d, l_d, en_d, cyc_d} = rd_entry;
                    cnt_d = rd_entry[CW-1:0];
                end
            end
            DRIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    res_data_d  = alu_f;
                    res_cout_d  = (op_q == 2'b00) ? alu_cout : 1'b0;
                    res_op_d    = op_q;
                    res_valid_d = 1'b1;
                end
            end
            RESP: if (res_ready) res_valid_d = 1'b0;
            default: ;
        endcase
    end

    // The counter op loads only in the first drive cycle (cnt still equals cyc), then counts.
    always_comb begin
        alu_x  = '0;
        alu_y  = '0;
        alu_s  = '0;
        alu_l  = 1'b0;
        alu_en = 1'b0;
        if (state_q == DRIVE) begin
            alu_x  = x_q;
            alu_y  = y_q;
            alu_s  = op_q;
            alu_en = en_q;
            alu_l  = l_q && ((op_q != 2'b10) || (cnt_q == cyc_q));
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            op_q        <= '0;
            x_q         <= '0;
            y_q         <= '0;
            l_q         <= 1'b0;
            en_q        <= 1'b0;
            cyc_q       <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_cout_q  <= 1'b0;
            res_op_q    <= '0;
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            op_q        <= op_d;
            x_q         <= x_d;
            y_q         <= y_d;
            l_q         <= l_d;
            en_q        <= en_d;
            cyc_q       <= cyc_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_cout_q  <= res_cout_d;
            res_op_q    <= res_op_d;
        end
    end

    assign cmd_ready = !full;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_cout  = res_cout_q;
    assign res_op    = res_op_q;
    assign busy      = (state_q != IDLE);
    assign level     = level_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a small ALU model on the alu_* pins, directed vectors,
// backpressure and reset corner cases, then randomized traffic against a reference model.
module tb_alu_sequencer;

    localparam int DEPTH = 4;
    localparam int CW    = 4;
    localparam int NRAND = 150;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0, cmd_ready;
    logic [1:0] cmd_op = '0;
    logic [7:0] cmd_x = '0, cmd_y = '0;
    logic       cmd_l = 1'b0, cmd_en = 1'b0;
    logic [3:0] cmd_cyc = '0;
    logic [7:0] alu_x, alu_y, alu_f;
    logic [1:0] alu_s;
    logic       alu_l, alu_en, alu_cout;
    logic       res_valid, res_ready = 1'b0;
    logic [7:0] res_data;
    logic       res_cout;
    logic [1:0] res_op;
    logic       busy;
    logic [2:0] level;

    alu_sequencer #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_l(cmd_l), .cmd_en(cmd_en), .cmd_cyc(cmd_cyc),
        .alu_x(alu_x), .alu_y(alu_y), .alu_s(alu_s), .alu_l(alu_l), .alu_en(alu_en),
        .alu_f(alu_f), .alu_cout(alu_cout),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_cout(res_cout), .res_op(res_op), .busy(busy), .level(level)
    );

    always #5 clock = ~clock;

    // ALU model: combinational adder/logic, registered shift register and counter.
    logic [7:0] a_cnt = '0, a_sr = '0;
    logic       alu_clr = 1'b0;
    logic [8:0] alu_sum;
    assign alu_sum  = {1'b0, alu_x} + {1'b0, alu_y} + {8'b0, alu_l};
    assign alu_cout = alu_sum[8];
    always_comb begin
        alu_f = '0;
        case (alu_s)
            2'b00: alu_f = alu_sum[7:0];
            2'b01: alu_f = a_sr;
            2'b10: alu_f = a_cnt;
            2'b11: alu_f = alu_x & alu_y;
            default: alu_f = '0;
        endcase
    end
    always @(posedge clock) begin
        if (alu_clr) begin
            a_cnt <= '0;
            a_sr  <= '0;
        end else begin
            if (alu_s == 2'b10) begin
                if (alu_l)       a_cnt <= alu_x;
                else if (alu_en) a_cnt <= a_cnt + 8'd1;
            end
            if (alu_s == 2'b01 && alu_en) a_sr <= {a_sr[6:0], alu_l};
        end
    end

    int n_chk = 0, n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [7:0] x, y;
        logic       l, en;
        logic [3:0] cyc;
        logic [7:0] d;
        logic       c;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       c;
        logic [1:0] op;
    } res_t;

    // Reference model state: what the ALU's registers hold between commands.
    logic [7:0] m_cnt, m_sr;

    function automatic res_t model(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y,
                                   input logic l, input logic en, input logic [3:0] cyc);
        res_t r;
        logic [8:0] s;
        logic [7:0] v;
        r.op = op;
        r.c  = 1'b0;
        r.d  = '0;
        case (op)
            2'b00: begin
                s = {1'b0, x} + {1'b0, y} + {8'b0, l};
                r.d = s[7:0];
                r.c = s[8];
            end
            2'b11: r.d = x & y;
            2'b01: begin
                v = m_sr;
                for (int k = 0; k <= int'(cyc); k++) begin
                    if (k == int'(cyc)) r.d = v;
                    if (en) v = {v[6:0], l};
                end
                m_sr = v;
            end
            default: begin
                v = m_cnt;
                for (int k = 0; k <= int'(cyc); k++) begin
                    if (k == int'(cyc)) r.d = v;
                    if (k == 0 && l) v = x;
                    else if (en)     v = v + 8'd1;
                end
                m_cnt = v;
            end
        endcase
        return r;
    endfunction

    task automatic drive_cmd(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y,
                             input logic l, input logic en, input logic [3:0] cyc);
        cmd_op = op; cmd_x = x; cmd_y = y; cmd_l = l; cmd_en = en; cmd_cyc = cyc;
    endtask

    // Single command from an idle, empty block with res_ready=1; checks every drive cycle.
    task automatic run_vec(input vec_t v, input int idx);
        int  n;
        bit  got;
        drive_cmd(v.op, v.x, v.y, v.l, v.en, v.cyc);
        cmd_valid = 1'b1;
        @(posedge clock); @(negedge clock);
        cmd_valid = 1'b0;
        check($sformatf("vec%0d_idle_alu", idx), {alu_x, alu_y, alu_s, alu_l, alu_en}, 0);
        check($sformatf("vec%0d_level", idx), level, 1);
        got = 0;
        for (n = 1; n <= 40; n++) begin
            @(posedge clock); @(negedge clock);
            if (res_valid) begin
                got = 1;
                break;
            end
            check($sformatf("vec%0d_drv%0d_xys", idx, n), {alu_x, alu_y, alu_s}, {v.x, v.y, v.op});
            check($sformatf("vec%0d_drv%0d_en", idx, n), alu_en, v.en);
            check($sformatf("vec%0d_drv%0d_l", idx, n), alu_l, v.l && (v.op != 2'b10 || n == 1));
        end
        if (!got) fail_now($sformatf("vec%0d_res_valid", idx));
        else begin
            check($sformatf("vec%0d_latency", idx), n, int'(v.cyc) + 2);
            check($sformatf("vec%0d_data", idx), res_data, v.d);
            check($sformatf("vec%0d_cout", idx), res_cout, v.c);
            check($sformatf("vec%0d_op", idx), res_op, v.op);
            check($sformatf("vec%0d_resp_alu", idx), {alu_x, alu_y, alu_s, alu_l, alu_en}, 0);
        end
        @(posedge clock); @(negedge clock);
        check($sformatf("vec%0d_done", idx), {res_valid, busy}, 0);
    endtask

    vec_t tbl[8];
    res_t expq[$];

    initial begin
        int pushed, got, sent, recv;
        bit six, any_valid, any_busy;
        res_t e;

        tbl[0] = '{2'b00, 8'h7F, 8'h01, 1'b1, 1'b0, 4'd0,  8'h81, 1'b0};
        tbl[1] = '{2'b00, 8'hFF, 8'h01, 1'b0, 1'b0, 4'd0,  8'h00, 1'b1};
        tbl[2] = '{2'b11, 8'hF0, 8'h3C, 1'b0, 1'b0, 4'd0,  8'h30, 1'b0};
        tbl[3] = '{2'b10, 8'h05, 8'hFF, 1'b1, 1'b1, 4'd3,  8'h07, 1'b0};
        tbl[4] = '{2'b00, 8'hA5, 8'h5A, 1'b1, 1'b1, 4'd15, 8'h00, 1'b1};
        tbl[5] = '{2'b01, 8'h00, 8'h00, 1'b1, 1'b1, 4'd8,  8'hFF, 1'b0};
        tbl[6] = '{2'b01, 8'h00, 8'h00, 1'b0, 1'b1, 4'd8,  8'h00, 1'b0};
        tbl[7] = '{2'b11, 8'h5A, 8'h0F, 1'b1, 1'b1, 4'd2,  8'h0A, 1'b0};

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_level", level, 0);
        check("rst_status", {res_valid, busy}, 0);
        check("rst_result", {res_data, res_cout, res_op}, 0);
        check("rst_alu", {alu_x, alu_y, alu_s, alu_l, alu_en}, 0);
        reset = 1'b1;
        res_ready = 1'b1;
        @(negedge clock);

        foreach (tbl[i]) run_vec(tbl[i], i);

        // Backpressure: six logic commands, result port stalled
        res_ready = 1'b0;
        pushed = 0;
        for (int t = 0; t < 40 && pushed < 5; t++) begin
            drive_cmd(2'b11, 8'h10 + 8'(pushed), 8'hFF, 1'b0, 1'b0, 4'd0);
            cmd_valid = 1'b1;
            if (cmd_ready) pushed++;
            @(posedge clock); @(negedge clock);
        end
        drive_cmd(2'b11, 8'h15, 8'hFF, 1'b0, 1'b0, 4'd0);
        for (int t = 0; t < 3; t++) begin
            @(posedge clock); @(negedge clock);
            check("bp_hold_data", res_data, 8'h10);
        end
        check("bp_level_full", level, 4);
        check("bp_cmd_ready", cmd_ready, 0);
        check("bp_status", {res_valid, busy, res_op}, {1'b1, 1'b1, 2'b11});
        res_ready = 1'b1;
        got = 0;
        six = 0;
        for (int t = 0; t < 80 && got < 6; t++) begin
            if (res_valid) begin
                check($sformatf("bp_order%0d", got), res_data, 8'h10 + 8'(got));
                got++;
            end
            if (cmd_valid && cmd_ready) six = 1;
            @(posedge clock); @(negedge clock);
            if (six) cmd_valid = 1'b0;
        end
        check("bp_sixth_accepted", six, 1);
        check("bp_drained", got, 6);
        repeat (2) @(negedge clock);

        // Reset in the third DRIVE cycle of a long counter command, one more queued
        drive_cmd(2'b10, 8'h20, 8'h00, 1'b1, 1'b1, 4'd7);
        cmd_valid = 1'b1;
        @(posedge clock); @(negedge clock);
        drive_cmd(2'b11, 8'hAA, 8'h55, 1'b0, 1'b0, 4'd0);
        @(posedge clock); @(negedge clock);
        cmd_valid = 1'b0;
        @(posedge clock); @(negedge clock);
        @(posedge clock); @(negedge clock);
        check("mid_drive_state", {busy, alu_s, level}, {1'b1, 2'b10, 3'd1});
        reset = 1'b0;
        #1;
        check("mid_rst_alu", {alu_x, alu_y, alu_s, alu_l, alu_en}, 0);
        check("mid_rst_level", level, 0);
        check("mid_rst_status", {busy, res_valid, cmd_ready}, 3'b001);
        @(negedge clock);
        reset = 1'b1;
        any_valid = 0;
        any_busy = 0;
        for (int t = 0; t < 20; t++) begin
            @(posedge clock); @(negedge clock);
            any_valid |= res_valid;
            any_busy  |= busy;
        end
        check("post_rst_no_valid", any_valid, 0);
        check("post_rst_no_busy", any_busy, 0);

        // Randomized traffic
        alu_clr = 1'b1;
        @(posedge clock); @(negedge clock);
        alu_clr = 1'b0;
        m_cnt = '0;
        m_sr = '0;
        sent = 0;
        recv = 0;
        for (int t = 0; t < 20000 && recv < NRAND; t++) begin
            res_ready = ($urandom_range(0, 3) != 0);
            if (res_valid && res_ready) begin
                if (expq.size() == 0) fail_now("rand_unexpected_result");
                else begin
                    e = expq.pop_front();
                    check($sformatf("rand%0d_data", recv), res_data, e.d);
                    check($sformatf("rand%0d_cout_op", recv), {res_cout, res_op}, {e.c, e.op});
                end
                recv++;
            end
            if (sent < NRAND && $urandom_range(0, 1) == 1) begin
                drive_cmd(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                          1'($urandom), 1'($urandom),
                          ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 4)));
                cmd_valid = 1'b1;
                if (cmd_ready) begin
                    expq.push_back(model(cmd_op, cmd_x, cmd_y, cmd_l, cmd_en, cmd_cyc));
                    sent++;
                end
            end else begin
                cmd_valid = 1'b0;
            end
            @(posedge clock); @(negedge clock);
        end
        cmd_valid = 1'b0;
        check("rand_recv_count", recv, NRAND);
        check("rand_queue_empty", expq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
